approx_add_sched: RTL and testbench

Round-robin scheduler that shares one runtime-configurable lower-part-OR approximate adder among `NUM_REQ` requesters. Each request carries operands, a per-request approximation width `k` and a requester tag. The block runs a 2-stage valid/ready pipeline with full backpressure and keeps running error statistics against the exact sum. It sits between the requesting accelerator lanes and the shared approximate-arithmetic datapath.

---
 rtl/approx_add_sched_pkg.sv | 36 +++
 rtl/loa_var_adder.sv | 31 +++
 rtl/approx_add_sched.sv | 152 +++++++++++++++
 tb/tb_approx_add_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_add_sched_pkg.sv
// Shared constants, width helpers and the reference LOA model for the
// round-robin approximate-adder scheduler.
package approx_pkg;

  localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;

  function automatic int calc_kw(input int approx_max);
    return $clog2(approx_max + 1);
  endfunction

  function automatic int calc_idw(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Bit-serial lower-part-OR adder; k must already be clamped by the caller.
  function automatic logic [31:0] loa_ref(input logic [31:0] a, input logic [31:0] b,
                                          input int k, input int width);
    logic [31:0] s;
    logic        c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        if (i < k) begin
          s[i] = a[i] | b[i];
          if (i == k - 1) c = a[i] & b[i];
        end else begin
          s[i] = a[i] ^ b[i] ^ c;
          c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/loa_var_adder.sv
// Combinational lower-part-OR adder with a runtime approximation width k;
// also produces the exact sum and the absolute error between the two.
module loa_var_adder #(
  parameter int WIDTH = 16,
  parameter int KW    = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] exact,
  output logic [WIDTH-1:0] err
);

  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] msb_mask;
  logic [WIDTH-1:0] upper;
  logic             cin;

  always_comb begin
    low_mask = ~({WIDTH{1'b1}} << k);
    // Single bit at position k-1 (empty when k = 0) locates the carry-in source.
    msb_mask = low_mask & ~(low_mask >> 1);
    cin      = |(a & b & msb_mask);
    upper    = (a & ~low_mask) + (b & ~low_mask) + ((msb_mask & {WIDTH{cin}}) << 1);
    sum      = (upper & ~low_mask) | ((a | b) & low_mask);
    exact    = a + b;
    err      = (exact >= sum) ? (exact - sum) : (sum - exact);
  end

endmodule

// File: rtl/approx_add_sched.sv
// Round-robin arbiter feeding a shared 2-stage LOA pipeline with full
// backpressure and running error statistics against the exact sum.
module approx_add_sched
  import approx_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int APPROX_MAX = 8,
  parameter  int NUM_REQ    = 4,
  localparam int KW         = calc_kw(APPROX_MAX),
  localparam int IDW        = calc_idw(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*KW-1:0]    req_k,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_sum,
  output logic [IDW-1:0]           resp_id,
  input  logic                     stats_clr,
  output logic [31:0]              err_total,
  output logic [WIDTH-1:0]         err_max,
  output logic [15:0]              resp_count
);

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [KW-1:0]    k_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    assign k_arr[i] = req_k[i*KW +: KW];
  end

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_id;
  logic             found;
  logic             accept;
  logic             s1_en;
  logic             s2_en;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [KW-1:0]    s1_k;
  logic [IDW-1:0]   s1_id;
  logic [KW-1:0]    k_sel;
  logic [KW-1:0]    k_eff;
  logic [WIDTH-1:0] loa_sum;
  logic [WIDTH-1:0] loa_exact_unused;
  logic [WIDTH-1:0] loa_err;
  logic             tot_carry;
  logic [31:0]      tot_sum;

  // NOTE: every variable driven in always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    logic [IDW-1:0] idx;
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
  end

  assign s2_en  = !resp_valid || resp_ready;
  assign s1_en  = !s1_valid || s2_en;
  // rst_n gates the grant so no requester sees an accept while in reset.
  assign accept = found && s1_en && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  assign k_sel = k_arr[grant_id];
  assign k_eff = (k_sel > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : k_sel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDW'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_k     <= '0;
      s1_id    <= '0;
    end else if (s1_en) begin
      s1_valid <= accept;
      if (accept) begin
        ptr   <= grant_id;
        s1_a  <= a_arr[grant_id];
        s1_b  <= b_arr[grant_id];
        s1_k  <= k_eff;
        s1_id <= grant_id;
      end
    end
  end

  loa_var_adder #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_loa (
    .a     (s1_a),
    .b     (s1_b),
    .k     (s1_k),
    .sum   (loa_sum),
    .exact (loa_exact_unused),
    .err   (loa_err)
  );

  assign {tot_carry, tot_sum} = {1'b0, err_total} + 33'(loa_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_id    <= '0;
      err_total  <= '0;
      err_max    <= '0;
      resp_count <= '0;
    end else begin
      if (s2_en) begin
        resp_valid <= s1_valid;
        if (s1_valid) begin
          resp_sum <= loa_sum;
          resp_id  <= s1_id;
        end
      end
      // A clear coinciding with a stage-2 load drops that sample.
      if (stats_clr) begin
        err_total  <= '0;
        err_max    <= '0;
        resp_count <= '0;
      end else if (s2_en && s1_valid) begin
        err_total  <= tot_carry ? ERR_SAT : tot_sum;
        err_max    <= (loa_err > err_max) ? loa_err : err_max;
        resp_count <= resp_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_approx_add_sched.sv
// Directed self-checking bench for approx_add_sched: arbitration order,
// latency, backpressure, LOA arithmetic, statistics clear and async reset.
module tb_approx_add_sched;
  import approx_pkg::*;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int KW  = 4;
  localparam int IDW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N*KW-1:0] req_k;
  logic            resp_valid;
  logic            resp_ready;
  logic [W-1:0]    resp_sum;
  logic [IDW-1:0]  resp_id;
  logic            stats_clr;
  logic [31:0]     err_total;
  logic [W-1:0]    err_max;
  logic [15:0]     resp_count;

  int n_tests = 0;
  int n_fail  = 0;

  approx_add_sched #(
    .WIDTH      (W),
    .APPROX_MAX (8),
    .NUM_REQ    (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_k      (req_k),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .stats_clr  (stats_clr),
    .err_total  (err_total),
    .err_max    (err_max),
    .resp_count (resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [KW-1:0] k);
    req_a[idx*W +: W]   = a;
    req_b[idx*W +: W]   = b;
    req_k[idx*KW +: KW] = k;
  endtask

  // One isolated transaction from requester idx; checks grant, 2-cycle latency,
  // sum, id and the error contributed to err_total.
  task automatic run_one(input string tag, input int idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [KW-1:0] k,
                         input logic [W-1:0] exp_sum, input logic [W-1:0] exp_err);
    logic [31:0]  tot0;
    logic [N-1:0] exp_ready;
    tot0           = err_total;
    exp_ready      = '0;
    exp_ready[idx] = 1'b1;
    set_req(idx, a, b, k);
    req_valid      = exp_ready;
    #1;
    check({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
    step();
    req_valid = '0;
    check({tag, " early"}, 32'(resp_valid), 32'd0);
    step();
    check({tag, " valid"}, 32'(resp_valid), 32'd1);
    check({tag, " sum"}, 32'(resp_sum), 32'(exp_sum));
    check({tag, " id"}, 32'(resp_id), 32'(idx));
    check({tag, " err"}, err_total - tot0, 32'(exp_err));
  endtask

  initial begin
    int           acc;
    int           nres;
    int           nxt;
    int           exp_id;
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [KW-1:0] vk [4];
    logic [W-1:0] es;
    logic [W-1:0] ex;
    logic [W-1:0] ee;

    rst_n      = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_k      = '0;
    resp_ready = 1'b1;
    stats_clr  = 1'b0;
    #1;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_sum", 32'(resp_sum), 32'd0);
    check("rst resp_id", 32'(resp_id), 32'd0);
    check("rst err_total", err_total, 32'd0);
    check("rst err_max", 32'(err_max), 32'd0);
    check("rst resp_count", 32'(resp_count), 32'd0);
    repeat (2) @(posedge clk);
    req_valid = '0;
    #3 rst_n = 1'b1;
    step();

    // Round robin with all requesters valid and no backpressure.
    for (int j = 0; j < N; j++) set_req(j, W'(16'h1111 * (j + 1)), W'(j + 1), 4'd0);
    req_valid = '1;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (n < 8) check("rr grant", 32'(req_ready), 32'(1) << (n % 4));
      if (n >= 2) begin
        check("rr valid", 32'(resp_valid), 32'd1);
        check("rr id", 32'(resp_id), 32'((n - 2) % 4));
        check("rr sum", 32'(resp_sum), 32'(16'h1112 * (((n - 2) % 4) + 1)));
      end else begin
        check("rr latency", 32'(resp_valid), 32'd0);
      end
      step();
    end
    req_valid = '0;
    check("rr tail0 id", 32'(resp_id), 32'd0);
    step();
    check("rr tail1 id", 32'(resp_id), 32'd1);
    step();
    check("rr drained", 32'(resp_valid), 32'd0);

    // Backpressure: pointer last granted requester 1, so 2 then 3 are accepted.
    nxt        = 2;
    acc        = 0;
    resp_ready = 1'b0;
    req_valid  = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        acc++;
        check("bp grant", 32'(req_ready), 32'(1) << nxt);
        nxt = (nxt + 1) % 4;
      end
      if (c >= 2) begin
        check("bp hold valid", 32'(resp_valid), 32'd1);
        check("bp hold id", 32'(resp_id), 32'd2);
        check("bp hold sum", 32'(resp_sum), 32'h3336);
      end
      step();
    end
    check("bp accepts", acc, 2);
    resp_ready = 1'b1;
    exp_id     = 2;
    nres       = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) req_valid = '0;
      #1;
      if (req_ready != '0) begin
        acc++;
        check("bp rel grant", 32'(req_ready), 32'(1) << nxt);
        nxt = (nxt + 1) % 4;
      end
      if (resp_valid) begin
        nres++;
        check("bp rel id", 32'(resp_id), 32'(exp_id));
        check("bp rel sum", 32'(resp_sum), 32'(16'h1112 * (exp_id + 1)));
        exp_id = (exp_id + 1) % 4;
      end
      step();
    end
    check("bp results", nres, 6);
    check("bp no loss", nres, acc);

    // Statistics clear, alone and coinciding with a stage-2 load.
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("clr total", err_total, 32'd0);
    check("clr max", 32'(err_max), 32'd0);
    check("clr count", 32'(resp_count), 32'd0);
    set_req(0, 16'h00FF, 16'h0001, 4'd8);
    req_valid = 4'b0001;
    repeat (11) @(posedge clk);
    #1;
    req_valid = '0;
    check("ten count", 32'(resp_count), 32'd10);
    check("ten total", err_total, 32'd10);
    check("ten max", 32'(err_max), 32'd1);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("coinc load", 32'(resp_valid), 32'd1);
    check("coinc total", err_total, 32'd0);
    check("coinc max", 32'(err_max), 32'd0);
    check("coinc count", 32'(resp_count), 32'd0);
    run_one("after clr", 0, 16'h00FF, 16'h0001, 4'd8, 16'h00FF, 16'd1);
    check("after clr total", err_total, 32'd1);
    check("after clr count", 32'(resp_count), 32'd1);

    // Directed LOA vectors.
    run_one("k8 ff+1", 0, 16'h00FF, 16'h00FF, 4'd8, 16'h01FF, 16'd1);
    run_one("k8 ffff", 0, 16'hFFFF, 16'hFFFF, 4'd8, 16'hFFFF, 16'd1);
    run_one("k8 aa+55", 0, 16'h00AA, 16'h0055, 4'd8, 16'h00FF, 16'd0);
    run_one("k0 exact", 0, 16'h00FF, 16'h0001, 4'd0, 16'h0100, 16'd0);
    run_one("k15 clamp", 0, 16'h0F00, 16'h0F00, 4'd15, 16'h1E00, 16'd0);
    run_one("k8 over", 0, 16'h0080, 16'h0080, 4'd8, 16'h0180, 16'h0080);
    run_one("k8 under", 0, 16'h0001, 16'h0001, 4'd8, 16'h0001, 16'd1);
    check("err_max", 32'(err_max), 32'h0080);
    check("resp_count", 32'(resp_count), 32'd8);

    // Mixed widths on other requesters, expected from the reference model.
    va = '{16'h1234, 16'hA5A5, 16'h7F80, 16'h0003};
    vb = '{16'h0FED, 16'h5A5A, 16'h0180, 16'h0001};
    vk = '{4'd4, 4'd8, 4'd12, 4'd1};
    for (int v = 0; v < 4; v++) begin
      es = W'(loa_ref(32'(va[v]), 32'(vb[v]), (vk[v] > 4'd8) ? 8 : int'(vk[v]), W));
      ex = va[v] + vb[v];
      ee = (ex >= es) ? (ex - es) : (es - ex);
      run_one("model", 1 + (v % 3), va[v], vb[v], vk[v], es, ee);
    end

    // Asynchronous reset with both stages full.
    for (int j = 0; j < N; j++) set_req(j, W'(16'h1111 * (j + 1)), W'(j + 1), 4'd0);
    resp_ready = 1'b0;
    req_valid  = '1;
    step();
    step();
    check("full valid", 32'(resp_valid), 32'd1);
    check("full stall", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst resp_valid", 32'(resp_valid), 32'd0);
    check("arst req_ready", 32'(req_ready), 32'd0);
    check("arst resp_sum", 32'(resp_sum), 32'd0);
    check("arst count", 32'(resp_count), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("post rst grant", 32'(req_ready), 32'b0001);
    step();
    check("post rst empty", 32'(resp_valid), 32'd0);
    step();
    check("post rst valid", 32'(resp_valid), 32'd1);
    check("post rst id", 32'(resp_id), 32'd0);
    check("post rst sum", 32'(resp_sum), 32'h1112);
    req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
